// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
package clock_pkg;

    localparam int TIME_W = 7;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_HI   = 4'b1100;
    localparam logic [3:0] MASK_LO   = 4'b0011;

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max_v);
        return (v == max_v) ? '0 : v + TIME_W'(1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / time-generator / display signal bundle for clock_set_ctrl.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic [TIME_W-1:0] cur_hour;
    logic [TIME_W-1:0] cur_min;
    logic              run_en;
    logic              set_load;
    logic [TIME_W-1:0] set_hour;
    logic [TIME_W-1:0] set_min;
    logic [3:0]        blink_mask;
    logic              editing;

    modport master (
        output btn_mode, btn_inc, cur_hour, cur_min,
        input  run_en, set_load, set_hour, set_min, blink_mask, editing
    );

    modport slave (
        input  btn_mode, btn_inc, cur_hour, cur_min,
        output run_en, set_load, set_hour, set_min, blink_mask, editing
    );

endinterface

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button.
// With CLOCK_SET_AUTOREPEAT_EN defined it also emits auto-repeat pulses while held.
module btn_edge #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic rpt_en_i,
    output logic press_o
);

    logic prev_q;
    logic edge_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= btn_i;
    end

    assign edge_s = btn_i & ~prev_q;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int FIRST = 2 * BLINK_DIV;
    localparam int RPT   = (BLINK_DIV / 4 < 1) ? 1 : BLINK_DIV / 4;
    localparam int CW    = $clog2(FIRST + 1);

    logic [CW-1:0] held_q, held_d, held_cur;
    logic          rpt_s;

    // held_cur is the held-cycle number of this cycle (press cycle = 1); after the
    // first repeat the counter is rewound so the next fires RPT cycles later.
    always_comb begin
        held_cur = held_q + CW'(1);
        held_d   = '0;
        rpt_s    = 1'b0;
        if (rpt_en_i && btn_i) begin
            if (held_cur == CW'(FIRST)) begin
                rpt_s  = 1'b1;
                held_d = CW'(FIRST - RPT);
            end else begin
                held_d = held_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) held_q <= '0;
        else     held_q <= held_d;
    end

    assign press_o = edge_s | rpt_s;
`else
    localparam int unused_div = BLINK_DIV;
    logic unused_rpt_en;
    assign unused_rpt_en = rpt_en_i;
    assign press_o       = edge_s;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN -> edit hour -> edit minute -> one-cycle load.
// Optional auto-repeat of the inc button via CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV = 25000000,
    parameter int HOUR_MAX  = 23,
    parameter int MIN_MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam int                BW   = $clog2(BLINK_DIV);
    localparam logic [TIME_W-1:0] HMAX = TIME_W'(HOUR_MAX);
    localparam logic [TIME_W-1:0] MMAX = TIME_W'(MIN_MAX);

    state_t            state_q, state_d;
    logic [TIME_W-1:0] hour_q, hour_d;
    logic [TIME_W-1:0] min_q, min_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [3:0]        mask_q, mask_d;
    logic              mode_press, inc_press, in_edit, inc_evt;

    assign in_edit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);

    btn_edge #(.BLINK_DIV(BLINK_DIV)) u_mode (
        .clk(clk), .rst(rst), .btn_i(bus.btn_mode), .rpt_en_i(1'b0), .press_o(mode_press)
    );

    btn_edge #(.BLINK_DIV(BLINK_DIV)) u_inc (
        .clk(clk), .rst(rst), .btn_i(bus.btn_inc), .rpt_en_i(in_edit & ~mode_press),
        .press_o(inc_press)
    );

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        inc_evt = in_edit & inc_press & ~mode_press;
        case (state_q)
            RUN: if (mode_press) begin
                hour_d  = bus.cur_hour;
                min_d   = bus.cur_min;
                state_d = EDIT_HOUR;
            end
            EDIT_HOUR: begin
                if (mode_press)   state_d = EDIT_MIN;
                else if (inc_evt) hour_d  = wrap_inc(hour_q, HMAX);
            end
            EDIT_MIN: begin
                if (mode_press)   state_d = COMMIT;
                else if (inc_evt) min_d   = wrap_inc(min_q, MMAX);
            end
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase

        // Entering an edit state or accepting an increment restarts the blink visible.
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (((state_d == EDIT_HOUR) || (state_d == EDIT_MIN)) &&
            ((state_d != state_q) || inc_evt)) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (in_edit) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
                phase_d = phase_q;
            end
        end

        mask_d = MASK_NONE;
        if ((state_d == state_q) && !inc_evt && phase_q) begin
            if (state_q == EDIT_HOUR)     mask_d = MASK_HI;
            else if (state_q == EDIT_MIN) mask_d = MASK_LO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            hour_q  <= '0;
            min_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            mask_q  <= MASK_NONE;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.run_en     = (state_q == RUN);
    assign bus.set_load   = (state_q == COMMIT);
    assign bus.editing    = in_edit;
    assign bus.set_hour   = hour_q;
    assign bus.set_min    = min_q;
    assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and random stimulus for clock_set_ctrl against a behavioural model.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    localparam int D    = 4;
    localparam int HMAX = 23;
    localparam int MMAX = 59;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int R    = (D / 4 < 1) ? 1 : D / 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.BLINK_DIV(D), .HOUR_MAX(HMAX), .MIN_MAX(MMAX)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // model state
    state_t     m_st;
    int         m_h, m_m, m_since;
    logic [3:0] m_mask;
    logic       m_pm, m_pi;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    int         m_k;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = RUN; m_h = 0; m_m = 0; m_since = 0;
        m_mask = 4'b0000; m_pm = 1'b0; m_pi = 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        m_k = 0;
`endif
    endtask

    task automatic check_outputs();
        chk("run_en",     {31'd0, bus.run_en},   {31'd0, m_st == RUN});
        chk("set_load",   {31'd0, bus.set_load}, {31'd0, m_st == COMMIT});
        chk("editing",    {31'd0, bus.editing},  {31'd0, (m_st == EDIT_HOUR) || (m_st == EDIT_MIN)});
        chk("set_hour",   {25'd0, bus.set_hour}, m_h);
        chk("set_min",    {25'd0, bus.set_min},  m_m);
        chk("blink_mask", {28'd0, bus.blink_mask}, {28'd0, m_mask});
    endtask

    task automatic model_next(input logic bm, input logic bi);
        logic mp, ip, edit, ph, fire, ie;
        state_t ns;
        logic [3:0] nm;
        mp   = bm & ~m_pm;
        ip   = bi & ~m_pi;
        edit = (m_st == EDIT_HOUR) || (m_st == EDIT_MIN);
        ph   = edit && (((m_since / D) % 2) == 1);
        fire = 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        if (edit && bi && !mp) begin
            m_k++;
            fire = (m_k >= 2 * D) && (((m_k - 2 * D) % R) == 0);
        end else begin
            m_k = 0;
        end
`endif
        ie = edit && !mp && (ip || fire);
        ns = m_st;
        case (m_st)
            RUN: if (mp) begin
                ns = EDIT_HOUR; m_h = int'(bus.cur_hour); m_m = int'(bus.cur_min);
            end
            EDIT_HOUR: if (mp) ns = EDIT_MIN; else if (ie) m_h = (m_h + 1) % (HMAX + 1);
            EDIT_MIN:  if (mp) ns = COMMIT;   else if (ie) m_m = (m_m + 1) % (MMAX + 1);
            default:   ns = RUN;
        endcase
        nm = 4'b0000;
        if (ns == m_st && !ie && ph) nm = (m_st == EDIT_HOUR) ? 4'b1100 : 4'b0011;
        if ((ns == EDIT_HOUR || ns == EDIT_MIN) && (ns != m_st || ie)) m_since = 0;
        else if (edit) m_since++;
        else m_since = 0;
        m_st = ns; m_mask = nm; m_pm = bm; m_pi = bi;
    endtask

    // Called at a falling edge: checks current outputs, drives inputs for the next rising edge.
    task automatic step(input logic bm, input logic bi);
        check_outputs();
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        model_next(bm, bi);
        @(negedge clk);
    endtask

    task automatic press(input logic bm, input logic bi);
        step(bm, bi);
        step(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        bus.cur_hour = 7'd10; bus.cur_min = 7'd30;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_run_en", {31'd0, bus.run_en}, 32'd1);
        chk("rst_set_load", {31'd0, bus.set_load}, 32'd0);
        chk("rst_mask", {28'd0, bus.blink_mask}, 32'd0);
        chk("rst_editing", {31'd0, bus.editing}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // capture and increment hour, wrap both fields
        step(1'b1, 1'b0);
        chk("cap_hour", {25'd0, bus.set_hour}, 32'd10);
        chk("cap_min", {25'd0, bus.set_min}, 32'd30);
        chk("cap_run_en", {31'd0, bus.run_en}, 32'd0);
        chk("cap_editing", {31'd0, bus.editing}, 32'd1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        chk("hour_13", {25'd0, bus.set_hour}, 32'd13);
        for (int i = 0; i < 10; i++) press(1'b0, 1'b1);
        chk("hour_23", {25'd0, bus.set_hour}, 32'd23);
        press(1'b0, 1'b1);
        chk("hour_wrap", {25'd0, bus.set_hour}, 32'd0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 29; i++) press(1'b0, 1'b1);
        chk("min_59", {25'd0, bus.set_min}, 32'd59);
        press(1'b0, 1'b1);
        chk("min_wrap", {25'd0, bus.set_min}, 32'd0);
        press(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // full sequence from 10:30
        press(1'b1, 1'b0);
        press(1'b0, 1'b1); press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("commit_load", {31'd0, bus.set_load}, 32'd1);
        chk("commit_hour", {25'd0, bus.set_hour}, 32'd12);
        chk("commit_min", {25'd0, bus.set_min}, 32'd35);
        step(1'b0, 1'b0);
        chk("after_commit_run", {31'd0, bus.run_en}, 32'd1);
        chk("after_commit_load", {31'd0, bus.set_load}, 32'd0);

        // blink in EDIT_MIN, then simultaneous mode+inc
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("simul_load", {31'd0, bus.set_load}, 32'd1);
        chk("simul_min", {25'd0, bus.set_min}, 32'd30);
        step(1'b0, 1'b0);

        // reset mid-edit
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_run_en", {31'd0, bus.run_en}, 32'd1);
        chk("midrst_load", {31'd0, bus.set_load}, 32'd0);
        chk("midrst_editing", {31'd0, bus.editing}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);

`ifdef CLOCK_SET_AUTOREPEAT_EN
        press(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        chk("autorpt_hour", {25'd0, bus.set_hour}, (10 + 2 + (40 - 2 * D) / R) % (HMAX + 1));
        step(1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        step(1'b0, 1'b0);
`endif

        for (int i = 0; i < 600; i++) begin
            bus.cur_hour = 7'($urandom_range(0, HMAX));
            bus.cur_min  = 7'($urandom_range(0, MMAX));
            step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-setting controller for the FPGA digital clock.
- Sits between two debounced push-buttons and the time generator / 4-digit 7-segment display.
- Sequences RUN -> edit hour -> edit minute -> commit. Holds the time generator while editing, then issues a one-cycle parallel load of the edited hour/minute.
- Drives a blink mask so the display flashes the digit pair being edited.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
- HOUR_MAX, 23, highest hour value; wraps to 0 after this.
- MIN_MAX, 59, highest minute value; wraps to 0 after this.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_mode  input  1  debounced, clk-synchronous level, mode button.
- btn_inc  input  1  debounced, clk-synchronous level, increment button.
- cur_hour  input  7  live hour from time generator, 0..HOUR_MAX.
- cur_min  input  7  live minute from time generator, 0..MIN_MAX.
- run_en  output  1  1 = time generator counts; 0 = frozen.
- set_load  output  1  one-cycle pulse; time generator loads set_hour/set_min, seconds cleared.
- set_hour  output  7  edited hour (shadow register).
- set_min  output  7  edited minute (shadow register).
- blink_mask  output  4  per-digit blank request to display; 1 = blank digit (bit3 = leftmost).
- editing  output  1  1 in EDIT_HOUR or EDIT_MIN.

Behaviour:
- Reset values: state RUN, run_en=1, set_load=0, set_hour=0, set_min=0, blink_mask=0, editing=0, blink counter=0, blink_phase=0, edge-detect registers=0.
- Press detection: registered copy of each button; press = level & ~prev, one cycle per press. Held buttons produce no further presses.
- Simultaneous presses: mode press has priority; an inc press in the same cycle is ignored.
- State RUN:
  - run_en=1, editing=0, blink_mask=0.
  - On mode press: capture cur_hour->set_hour and cur_min->set_min; go to EDIT_HOUR.
  - run_en drops on the cycle after the press edge (1-cycle latency).
- State EDIT_HOUR:
  - run_en=0, editing=1.
  - On inc press: set_hour = (set_hour==HOUR_MAX) ? 0 : set_hour+1.
  - On mode press: go to EDIT_MIN.
- State EDIT_MIN:
  - run_en=0.
  - On inc press: set_min = (set_min==MIN_MAX) ? 0 : set_min+1.
  - On mode press: go to COMMIT.
- State COMMIT (one cycle):
  - set_load=1, run_en=0, editing=0, blink_mask=0.
  - Unconditionally go to RUN on the next cycle.
  - Buttons are ignored in COMMIT.
- set_hour/set_min:
  - Hold their value in COMMIT and RUN until the next capture.
  - Shadow values above MIN_MAX/HOUR_MAX are impossible.
- Blink counter:
  - Runs only in EDIT states, counting 0..BLINK_DIV-1.
  - On terminal count: wraps to 0 and toggles blink_phase.
  - Counter and phase clear to 0 on every EDIT_HOUR/EDIT_MIN entry, so the edited digits are visible immediately.
  - Any inc press also clears counter and phase, so the new value is visible at once.
- blink_mask (registered, 1-cycle latency from state/phase):
  - EDIT_HOUR with phase=1 -> 4'b1100.
  - EDIT_MIN with phase=1 -> 4'b0011.
  - Otherwise -> 4'b0000.
- Reset mid-edit: returns immediately to RUN with run_en=1. No set_load is issued; edits are discarded.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- When defined:
  - Holding btn_inc in an EDIT state generates a first repeat increment after 2*BLINK_DIV cycles held.
  - Further increments follow every BLINK_DIV/4 cycles while held.
  - The repeat counter clears on release or on any state change.
  - Wrap rules are identical to single presses.
- When undefined: increments occur only on press edges; repeat logic is absent.

Decomposition:
- Shared package clock_pkg:
  - State enum (RUN, EDIT_HOUR, EDIT_MIN, COMMIT).
  - Field-width constant TIME_W=7.
  - Blink mask constants MASK_NONE, MASK_HI, MASK_LO.
- Sub-module btn_edge: one instance per button; registered rising-edge detector; also hosts the auto-repeat counter when the macro is defined.
- Everything else stays in clock_set_ctrl.

Test Plan:
- Reset release with cur_hour=10, cur_min=30 -> run_en=1, set_load=0, blink_mask=0, editing=0.
- Mode press with cur_hour=10, cur_min=30 -> set_hour=10, set_min=30, run_en=0 next cycle, editing=1. Then 3 inc presses -> set_hour=13.
- In EDIT_HOUR with set_hour=23, inc press -> set_hour=0. In EDIT_MIN with set_min=59, inc press -> set_min=0.
- Full sequence mode, inc x2, mode, inc x5, mode from 10:30 -> exactly one set_load pulse with set_hour=12, set_min=35. run_en=1 on the following cycle.
- BLINK_DIV=4 in EDIT_MIN, no presses -> blink_mask alternates 0000/0011 every 4 cycles. Mode and inc pressed in the same cycle -> state advances, set_min unchanged.
- Assert rst in EDIT_MIN -> state RUN, run_en=1 immediately, no set_load pulse. With CLOCK_SET_AUTOREPEAT_EN and BLINK_DIV=8, holding inc 40 cycles -> 1 press increment plus 1+floor((40-16)/2) repeat increments.
